// File: rtl/fsm_stim_sequencer_pkg.sv
// Shared types and limits for the lab-fsm stimulus sequencer.
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RST   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int WIDTH_MIN      = 2;
    localparam int WIDTH_MAX      = 32;
    localparam int RST_CYCLES_MIN = 1;
    localparam int RST_CYCLES_MAX = 15;
    localparam int CAP_DLY_MAX    = 3;

    // Cycle counter must cover WIDTH_MAX + CAP_DLY_MAX and RST_CYCLES_MAX.
    localparam int CNT_W = 6;

    // Oversized lengths are clamped silently to the pattern width.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
        return (len > width) ? width : len;
    endfunction

endpackage

// File: rtl/fsm_stim_sequencer_bit_delay_line.sv
// Fixed-depth register delay line; DEPTH=0 degenerates to a wire.
module bit_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        assign q_o = d_i;
    end else begin : g_dly
        logic [W-1:0] stage_q [DEPTH];

        // Shift the token one stage per clock; reset flushes any in-flight token.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/fsm_stim_sequencer.sv
// Drives a bit pattern LSB-first into the lab fsm and collects its Out samples.
module fsm_stim_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int RST_CYCLES = 2,
    parameter int CAP_DLY    = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [WIDTH-1:0]           req_pattern,
    input  logic [$clog2(WIDTH+1)-1:0] req_len,
    input  logic                       req_clr,
    output logic                       fsm_reset,
    output logic                       fsm_in,
    input  logic                       fsm_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_result,
    output logic [$clog2(WIDTH+1)-1:0] rsp_hits,
    output logic                       busy
);

    localparam int LEN_W = $clog2(WIDTH + 1);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int TOK_W = IDX_W + 1;

    seq_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] result_q;
    logic [LEN_W-1:0] hits_q;

    logic [LEN_W-1:0] len_clamp_d;
    logic             rst_last_d;
    logic             shift_last_d;
    logic             drive_en_d;
    logic [TOK_W-1:0] tok_d;
    logic [TOK_W-1:0] tok_dly;
    logic             smp_en;
    logic [IDX_W-1:0] smp_idx;

    assign len_clamp_d  = LEN_W'(clamp_len(32'(req_len), WIDTH));
    assign rst_last_d   = (32'(cnt_q) == 32'(RST_CYCLES - 1));
    assign shift_last_d = (32'(cnt_q) == 32'(len_q) + 32'(CAP_DLY) - 32'd1);
    assign drive_en_d   = (32'(cnt_q) < 32'(len_q));

    // A sample token is issued for every driven bit, then delayed to meet its fsm_out.
    assign tok_d   = {(state_q == SHIFT) && drive_en_d, cnt_q[IDX_W-1:0]};
    assign smp_en  = tok_dly[IDX_W];
    assign smp_idx = tok_dly[IDX_W-1:0];

    bit_delay_line #(
        .DEPTH (CAP_DLY),
        .W     (TOK_W)
    ) u_tok_dly (
        .clk_i   (clock),
        .rst_n_i (reset),
        .d_i     (tok_d),
        .q_o     (tok_dly)
    );

    // Sequencer FSM together with its counter, pattern shifter and result capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            pat_q    <= '0;
            result_q <= '0;
            hits_q   <= '0;
        end else begin
            if (smp_en) begin
                result_q[smp_idx] <= fsm_out;
                if (fsm_out) hits_q <= hits_q + LEN_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        pat_q    <= req_pattern;
                        len_q    <= len_clamp_d;
                        result_q <= '0;
                        hits_q   <= '0;
                        cnt_q    <= '0;
                        if (req_clr)                state_q <= RST;
                        else if (len_clamp_d == '0) state_q <= DONE;
                        else                        state_q <= SHIFT;
                    end
                end
                RST: begin
                    if (rst_last_d) begin
                        cnt_q   <= '0;
                        state_q <= (len_q == '0) ? DONE : SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    pat_q <= pat_q >> 1;
                    if (shift_last_d) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode the state register; reset low forces them quiet and holds the fsm in reset.
    always_comb begin
        req_ready  = reset && (state_q == IDLE);
        fsm_reset  = !reset || (state_q == RST);
        fsm_in     = reset && (state_q == SHIFT) && drive_en_d && pat_q[0];
        rsp_valid  = reset && (state_q == DONE);
        rsp_result = reset ? result_q : '0;
        rsp_hits   = reset ? hits_q : '0;
        busy       = reset && (state_q != IDLE);
    end

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// Directed bench for fsm_stim_sequencer with a one-cycle echo model of the lab fsm.
module tb_fsm_stim_sequencer;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_pattern;
    logic [3:0] req_len;
    logic       req_clr;
    logic       fsm_reset;
    logic       fsm_in;
    logic       fsm_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [3:0] rsp_hits;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] res;
        logic [3:0] hits;
        int         lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] rst_trace;
    logic [63:0] in_trace;
    logic        fsm_q;

    fsm_stim_sequencer #(
        .WIDTH      (8),
        .RST_CYCLES (2),
        .CAP_DLY    (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pattern (req_pattern),
        .req_len     (req_len),
        .req_clr     (req_clr),
        .fsm_reset   (fsm_reset),
        .fsm_in      (fsm_in),
        .fsm_out     (fsm_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_hits    (rsp_hits),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Lab fsm stand-in: Out is In delayed by one clock, cleared by its reset.
    always @(posedge clock) fsm_q <= fsm_reset ? 1'b0 : fsm_in;
    assign fsm_out = fsm_q;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] pat, input logic [3:0] len, input logic clr);
        exp_t e;
        int   l;
        l      = (len > 8) ? 8 : int'(len);
        e.res  = '0;
        for (int i = 0; i < l; i++) e.res[i] = pat[i];
        e.hits = 4'($countones(e.res));
        e.lat  = 1 + (clr ? 2 : 0) + ((l != 0) ? l + 1 : 0);
        return e;
    endfunction

    // Issue one request, wait for the response, optionally stall it, then consume it.
    task automatic run_req(input string tag, input logic [7:0] pat, input logic [3:0] len,
                           input logic clr, input int hold);
        exp_t e;
        int   cyc;
        rst_trace = '0;
        in_trace  = '0;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_pattern = pat;
        req_len     = len;
        req_clr     = clr;
        sb_q.push_back(model(pat, len, clr));
        step();
        req_valid = 1'b0;
        cyc = 1;
        while (cyc < 60) begin
            rst_trace[cyc] = fsm_reset;
            in_trace[cyc]  = fsm_in;
            if (rsp_valid) break;
            step();
            cyc++;
        end
        e = sb_q.pop_front();
        chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        chk({tag, "_result"}, 32'(rsp_result), 32'(e.res));
        chk({tag, "_hits"}, 32'(rsp_hits), 32'(e.hits));
        for (int h = 0; h < hold; h++) begin
            req_valid   = 1'b1;
            req_pattern = 8'hFF;
            req_len     = 4'd8;
            req_clr     = 1'b0;
            step();
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_result"}, 32'(rsp_result), 32'(e.res));
            chk({tag, "_hold_hits"}, 32'(rsp_hits), 32'(e.hits));
            chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        bit seen;
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_pattern = '0;
        req_len     = '0;
        req_clr     = 1'b0;
        rsp_ready   = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_fsm_reset", 32'(fsm_reset), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_fsm_in", 32'(fsm_in), 32'd0);
        chk("rst_result", 32'(rsp_result), 32'd0);
        chk("rst_hits", 32'(rsp_hits), 32'd0);
        reset = 1'b1;
        step();
        chk("post_rst_fsm_reset", 32'(fsm_reset), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // 1: full pattern with fsm reset pulse
        run_req("t1", 8'hB2, 4'd8, 1'b1, 0);
        chk("t1_rst_window", 32'(rst_trace[12:0]), 32'h0006);

        // 2: zero length
        run_req("t2", 8'hB2, 4'd0, 1'b0, 0);
        chk("t2_fsm_in", 32'(in_trace[1:0]), 32'd0);

        // 3: short pattern with drain cycle
        run_req("t3", 8'hFF, 4'd3, 1'b0, 0);
        chk("t3_in_window", 32'(in_trace[5:0]), 32'h0E);

        // 4: response stall with an ignored request in flight
        run_req("t4", 8'h3C, 4'd6, 1'b0, 5);
        step();
        chk("t4_no_queue_busy", 32'(busy), 32'd0);

        // 5: reset pulse during SHIFT bit 4
        req_valid   = 1'b1;
        req_pattern = 8'hFF;
        req_len     = 4'd8;
        req_clr     = 1'b0;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        chk("t5_bit4_in", 32'(fsm_in), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_rstcyc_fsm_reset", 32'(fsm_reset), 32'd1);
        chk("t5_rstcyc_fsm_in", 32'(fsm_in), 32'd0);
        chk("t5_rstcyc_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b1;
        #1;
        chk("t5_after_busy", 32'(busy), 32'd0);
        chk("t5_after_valid", 32'(rsp_valid), 32'd0);
        chk("t5_after_fsm_in", 32'(fsm_in), 32'd0);
        chk("t5_after_fsm_reset", 32'(fsm_reset), 32'd0);
        chk("t5_after_ready", 32'(req_ready), 32'd1);
        chk("t5_after_result", 32'(rsp_result), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid || busy) seen = 1'b1;
        end
        chk("t5_aborted_quiet", 32'(seen), 32'd0);

        // 6: oversized length clamps to the pattern width
        run_req("t6", 8'h5A, 4'd12, 1'b0, 0);

        // 7: top and bottom bits set, then reset pulse with empty pattern
        run_req("t7", 8'h81, 4'd8, 1'b0, 0);
        run_req("t8", 8'hA5, 4'd0, 1'b1, 0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
